// File: rtl/blackjack_pkg.sv
// Shared constants and state encoding for the blackjack card-dealing blocks.
package blackjack_pkg;

    localparam int DECK_SIZE_DEFAULT = 52;
    localparam int CARD_W = 4;
    localparam int ADDR_W = 6;

    typedef enum logic [2:0] {
        ST_WAIT_SHUF = 3'd0,
        ST_IDLE      = 3'd1,
        ST_READ      = 3'd2,
        ST_DELIVER   = 3'd3,
        ST_EMPTY     = 3'd4
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin chooser: a tie goes to the side that did not win the previous tie.
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] grant
);

    // last = 1 means the dealer (req[1]) won the most recent tie
    logic last;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            last <= 1'b1;
        end else if (take && (req == 2'b11)) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/deck_arbiter.sv
// Deals cards from a shuffled deck memory to player and dealer, one outstanding request each.
module deck_arbiter
    import blackjack_pkg::*;
#(
    parameter int DECK_SIZE    = DECK_SIZE_DEFAULT,
    parameter int READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              shuffle_ok,
    input  logic              new_round,
    input  logic              req_player,
    input  logic              req_dealer,
    input  logic [CARD_W-1:0] card_q,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [CARD_W-1:0] card,
    output logic              ack_player,
    output logic              ack_dealer,
    output logic              busy,
    output logic              deck_empty,
    output logic [ADDR_W-1:0] cards_dealt,
    output logic [2:0]        state_dbg
);

    localparam logic [1:0]        LAT_LAST = 2'(READ_LATENCY - 1);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DECK_SIZE - 1);
    localparam logic [ADDR_W-1:0] FULL_CNT = ADDR_W'(DECK_SIZE);

    state_e            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] dealt;
    logic [1:0]        pend;       // bit 0 player, bit 1 dealer
    logic [1:0]        pend_next;
    logic              target;     // 0 player, 1 dealer
    logic              init_run;
    logic [1:0]        step;
    logic [1:0]        lat_cnt;
    logic [1:0]        grant;
    logic              arb_take;
    logic              read_done;

    assign read_done = (state == ST_READ) && (lat_cnt == LAT_LAST);
    assign arb_take  = (state == ST_IDLE) && !new_round && (pend != 2'b00);

    rr_arb2 u_rr_arb2 (
        .clock (clock),
        .reset (reset),
        .req   (pend),
        .take  (arb_take),
        .grant (grant)
    );

    // Init-deal cards leave the pending flags alone so queued requests survive the deal.
    always_comb begin
        pend_next = pend;
        if (state inside {ST_IDLE, ST_READ, ST_DELIVER}) begin
            if (req_player) pend_next[0] = 1'b1;
            if (req_dealer) pend_next[1] = 1'b1;
        end
        if (read_done && !init_run) begin
            pend_next[target] = 1'b0;
        end
        if ((state == ST_EMPTY) || ((state == ST_DELIVER) && (dealt == FULL_CNT))) begin
            pend_next = 2'b00;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= ST_WAIT_SHUF;
            ptr      <= '0;
            dealt    <= '0;
            pend     <= 2'b00;
            target   <= 1'b0;
            init_run <= 1'b0;
            step     <= 2'd0;
            lat_cnt  <= 2'd0;
            card     <= '0;
        end else if (!shuffle_ok) begin
            state    <= ST_WAIT_SHUF;
            ptr      <= '0;
            dealt    <= '0;
            pend     <= 2'b00;
            init_run <= 1'b0;
            step     <= 2'd0;
            lat_cnt  <= 2'd0;
        end else begin
            pend <= pend_next;
            case (state)
                ST_WAIT_SHUF: state <= ST_IDLE;
                ST_IDLE: begin
                    if (new_round) begin
                        state    <= ST_READ;
                        target   <= 1'b0;
                        init_run <= 1'b1;
                        step     <= 2'd0;
                        lat_cnt  <= 2'd0;
                    end else if (pend != 2'b00) begin
                        state    <= ST_READ;
                        target   <= grant[1];
                        init_run <= 1'b0;
                        lat_cnt  <= 2'd0;
                    end
                end
                // Pointer advances as the card is captured, so the next address is
                // already on rd_addr during DELIVER and memory latency overlaps it.
                ST_READ: begin
                    if (read_done) begin
                        card  <= card_q;
                        dealt <= dealt + ADDR_W'(1);
                        if (ptr != LAST_PTR) ptr <= ptr + ADDR_W'(1);
                        state <= ST_DELIVER;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                ST_DELIVER: begin
                    if (dealt == FULL_CNT) begin
                        state    <= ST_EMPTY;
                        init_run <= 1'b0;
                    end else if (init_run && (step != 2'd3)) begin
                        state   <= ST_READ;
                        step    <= step + 2'd1;
                        target  <= ~target;
                        lat_cnt <= 2'd0;
                    end else begin
                        state    <= ST_IDLE;
                        init_run <= 1'b0;
                    end
                end
                ST_EMPTY: state <= ST_EMPTY;
                default:  state <= ST_WAIT_SHUF;
            endcase
        end
    end

    assign rd_addr     = ptr;
    assign ack_player  = (state == ST_DELIVER) && !target;
    assign ack_dealer  = (state == ST_DELIVER) && target;
    assign busy        = (state != ST_IDLE);
    assign deck_empty  = (state == ST_EMPTY);
    assign cards_dealt = dealt;
    assign state_dbg   = state;

endmodule

// File: tb/tb_deck_arbiter.sv
// Directed bench for deck_arbiter: a 52-card/latency-1 instance and a 4-card/latency-2 instance.
module tb_deck_arbiter;

    localparam logic [2:0] S_WAIT = 3'd0;
    localparam logic [2:0] S_IDLE = 3'd1;
    localparam logic [2:0] S_READ = 3'd2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       shuf = 1'b1, new_round = 1'b0, req_p = 1'b0, req_d = 1'b0;
    logic [3:0] card_q = 4'd0;
    logic [5:0] rd_addr, dealt;
    logic [3:0] card;
    logic       ack_p, ack_d, busy, empty;
    logic [2:0] st;

    logic       s_shuf = 1'b1, s_new_round = 1'b0, s_req_p = 1'b0, s_req_d = 1'b0;
    logic [3:0] s_card_q = 4'd0, s_d1 = 4'd0;
    logic [5:0] s_rd_addr, s_dealt;
    logic [3:0] s_card;
    logic       s_ack_p, s_ack_d, s_busy, s_empty;
    logic [2:0] s_st;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int overlap = 0;

    logic [4:0] exp_q[$];
    logic [4:0] act_q[$];
    logic [5:0] addr_q[$];
    logic [5:0] dealt_q[$];
    int         cyc_q[$];

    deck_arbiter u_big (
        .clock(clock), .reset(reset), .shuffle_ok(shuf), .new_round(new_round),
        .req_player(req_p), .req_dealer(req_d), .card_q(card_q), .rd_addr(rd_addr),
        .card(card), .ack_player(ack_p), .ack_dealer(ack_d), .busy(busy),
        .deck_empty(empty), .cards_dealt(dealt), .state_dbg(st)
    );

    deck_arbiter #(.DECK_SIZE(4), .READ_LATENCY(2)) u_small (
        .clock(clock), .reset(reset), .shuffle_ok(s_shuf), .new_round(s_new_round),
        .req_player(s_req_p), .req_dealer(s_req_d), .card_q(s_card_q), .rd_addr(s_rd_addr),
        .card(s_card), .ack_player(s_ack_p), .ack_dealer(s_ack_d), .busy(s_busy),
        .deck_empty(s_empty), .cards_dealt(s_dealt), .state_dbg(s_st)
    );

    // ---------------- clock / memory model / monitor ----------------
    always #5 clock = ~clock;

    function automatic logic [3:0] mem_f(input logic [5:0] a);
        logic [7:0] t;
        t = {2'b00, a} * 8'd5 + 8'd7;
        return t[3:0];
    endfunction

    always @(posedge clock) begin
        cyc      <= cyc + 1;
        card_q   <= mem_f(rd_addr);
        s_d1     <= mem_f(s_rd_addr);
        s_card_q <= s_d1;
    end

    always @(negedge clock) begin
        if (ack_p && ack_d) overlap = 1;
        if (ack_p || ack_d) begin
            act_q.push_back({ack_d, card});
            addr_q.push_back(rd_addr);
            dealt_q.push_back(dealt);
            cyc_q.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_log();
        act_q.delete(); addr_q.delete(); dealt_q.delete(); cyc_q.delete(); exp_q.delete();
        overlap = 0;
    endtask

    task automatic pulse(input logic p, input logic d, input logic nr, output int c);
        @(negedge clock);
        req_p = p; req_d = d; new_round = nr; c = cyc;
        @(negedge clock);
        req_p = 1'b0; req_d = 1'b0; new_round = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; shuf = 1'b1; s_shuf = 1'b1;
        repeat (2) @(negedge clock);
        total++; if (st !== S_WAIT) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", st, S_WAIT); end
        total++; if ({rd_addr, card, dealt} !== 16'd0) begin bad++; $display("FAIL reset_regs got=%h exp=0", {rd_addr, card, dealt}); end
        total++; if ({ack_p, ack_d, busy, empty} !== 4'b0010) begin bad++; $display("FAIL reset_flags got=%b exp=0010", {ack_p, ack_d, busy, empty}); end
        total++; if (s_busy !== 1'b1) begin bad++; $display("FAIL reset_small_busy got=%b exp=1", s_busy); end
        reset = 1'b1;
        @(negedge clock);
        total++; if (st !== S_IDLE) begin bad++; $display("FAIL release_state got=%0d exp=%0d", st, S_IDLE); end
        total++; if ({busy, s_busy} !== 2'b00) begin bad++; $display("FAIL release_busy got=%b exp=00", {busy, s_busy}); end
    endtask

    task automatic test_single_req();
        int c;
        clear_log();
        pulse(1'b1, 1'b0, 1'b0, c);
        repeat (6) @(negedge clock);
        total++; if (act_q.size() !== 1) begin bad++; $display("FAIL single_count got=%0d exp=1", act_q.size()); end
        if (act_q.size() == 1) begin
            total++; if (act_q[0] !== 5'h07) begin bad++; $display("FAIL single_card got=%h exp=07", act_q[0]); end
            total++; if ({addr_q[0], dealt_q[0]} !== {6'd1, 6'd1}) begin bad++; $display("FAIL single_addr_dealt got=%0d/%0d exp=1/1", addr_q[0], dealt_q[0]); end
            total++; if (cyc_q[0] - c !== 3) begin bad++; $display("FAIL single_latency got=%0d exp=3", cyc_q[0] - c); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", busy); end
    endtask

    task automatic test_round_robin();
        int c;
        clear_log();
        pulse(1'b1, 1'b1, 1'b0, c);
        repeat (10) @(negedge clock);
        pulse(1'b1, 1'b1, 1'b0, c);
        repeat (10) @(negedge clock);
        exp_q = '{5'h0C, 5'h11, 5'h16, 5'h0B};
        total++; if (act_q.size() !== exp_q.size()) begin bad++; $display("FAIL rr_count got=%0d exp=%0d", act_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            total++; if (act_q[i] !== exp_q[i]) begin bad++; $display("FAIL rr_ack%0d got=%h exp=%h", i, act_q[i], exp_q[i]); end
        end
        total++; if (overlap !== 0) begin bad++; $display("FAIL rr_overlap got=%0d exp=0", overlap); end
    endtask

    task automatic test_init_deal();
        int c;
        @(negedge clock);
        shuf = 1'b0;
        @(negedge clock);
        total++; if ({st, dealt, rd_addr} !== {S_WAIT, 6'd0, 6'd0}) begin bad++; $display("FAIL reshuffle_clear got=%0d/%0d/%0d exp=0/0/0", st, dealt, rd_addr); end
        shuf = 1'b1;
        @(negedge clock);
        total++; if (st !== S_IDLE) begin bad++; $display("FAIL reshuffle_idle got=%0d exp=%0d", st, S_IDLE); end
        clear_log();
        pulse(1'b0, 1'b0, 1'b1, c);
        pulse(1'b0, 1'b1, 1'b0, c);
        repeat (16) @(negedge clock);
        exp_q = '{5'h07, 5'h1C, 5'h01, 5'h16, 5'h1B};
        total++; if (act_q.size() !== exp_q.size()) begin bad++; $display("FAIL deal_count got=%0d exp=%0d", act_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            total++; if (act_q[i] !== exp_q[i]) begin bad++; $display("FAIL deal_ack%0d got=%h exp=%h", i, act_q[i], exp_q[i]); end
        end
        if (act_q.size() == 5) begin
            total++; if ({addr_q[4], dealt_q[4]} !== {6'd5, 6'd5}) begin bad++; $display("FAIL deal_final got=%0d/%0d exp=5/5", addr_q[4], dealt_q[4]); end
        end
        total++; if (overlap !== 0) begin bad++; $display("FAIL deal_overlap got=%0d exp=0", overlap); end
    endtask

    task automatic test_abort();
        int  c;
        logic seen;
        clear_log();
        pulse(1'b1, 1'b0, 1'b0, c);
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clock);
            if (st === S_READ) seen = 1'b1;
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL abort_reach_read got=%b exp=1", seen); end
        shuf = 1'b0;
        @(negedge clock);
        total++; if ({st, dealt, ack_p} !== {S_WAIT, 6'd0, 1'b0}) begin bad++; $display("FAIL abort_state got=%0d/%0d/%b exp=0/0/0", st, dealt, ack_p); end
        repeat (4) @(negedge clock);
        shuf = 1'b1;
        repeat (4) @(negedge clock);
        total++; if (act_q.size() !== 0) begin bad++; $display("FAIL abort_no_ack got=%0d exp=0", act_q.size()); end
    endtask

    task automatic test_empty();
        int   c, n_ack;
        logic got;
        logic [3:0] got_card;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            s_req_p = 1'b1; c = cyc;
            got = 1'b0; got_card = 4'd0; n_ack = 0;
            for (int n = 1; n <= 10 && !got; n++) begin
                @(negedge clock);
                s_req_p = 1'b0;
                if (s_ack_p) begin got = 1'b1; got_card = s_card; n_ack = cyc - c; end
            end
            if (k < 4) begin
                total++; if ({got, got_card} !== {1'b1, mem_f(6'(k))}) begin bad++; $display("FAIL empty_ack%0d got=%b/%0d exp=1/%0d", k, got, got_card, mem_f(6'(k))); end
                if (k == 0) begin
                    total++; if (n_ack !== 4) begin bad++; $display("FAIL lat2_latency got=%0d exp=4", n_ack); end
                end
                if (k == 3) begin
                    @(negedge clock);
                    total++; if ({s_empty, s_dealt} !== {1'b1, 6'd4}) begin bad++; $display("FAIL empty_flag got=%b/%0d exp=1/4", s_empty, s_dealt); end
                end
            end else begin
                total++; if (got !== 1'b0) begin bad++; $display("FAIL empty_fifth got=%b exp=0", got); end
                total++; if ({s_empty, s_busy} !== 2'b11) begin bad++; $display("FAIL empty_hold got=%b exp=11", {s_empty, s_busy}); end
            end
        end
        s_shuf = 1'b0;
        @(negedge clock);
        total++; if ({s_st, s_empty} !== {S_WAIT, 1'b0}) begin bad++; $display("FAIL empty_exit got=%0d/%b exp=0/0", s_st, s_empty); end
        s_shuf = 1'b1;
        @(negedge clock);
        total++; if ({s_st, s_rd_addr, s_dealt} !== {S_IDLE, 6'd0, 6'd0}) begin bad++; $display("FAIL empty_reidle got=%0d/%0d/%0d exp=1/0/0", s_st, s_rd_addr, s_dealt); end
    endtask

    task automatic test_reset_mid_read();
        int   c;
        logic seen;
        clear_log();
        pulse(1'b0, 1'b1, 1'b0, c);
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clock);
            if (st === S_READ) seen = 1'b1;
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL rst_reach_read got=%b exp=1", seen); end
        reset = 1'b0;
        @(negedge clock);
        total++; if ({st, busy, ack_d, rd_addr} !== {S_WAIT, 1'b1, 1'b0, 6'd0}) begin bad++; $display("FAIL rst_mid_read got=%0d/%b/%b/%0d exp=0/1/0/0", st, busy, ack_d, rd_addr); end
        reset = 1'b1;
        repeat (6) @(negedge clock);
        total++; if ({act_q.size() == 0, busy} !== 2'b10) begin bad++; $display("FAIL rst_no_ack got=%0d/%b exp=0/0", act_q.size(), busy); end
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        test_reset();
        test_single_req();
        test_round_robin();
        test_init_deal();
        test_abort();
        test_empty();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
